// File: rtl/car_pkg.sv
// Shared types and constants for the car-dashboard lab.
//   gear_e         : gear switch encoding (N, 1..6, R)
//   MAX_LEVEL      : top speed level allowed per gear, indexed by gear_e
//   SEG_*          : 7-seg glyphs, bit order {dp,g,f,e,d,c,b,a}, active-high
//   *_DEFAULT      : auto-repeat timing in control ticks
//   BEEP_*_TICKS   : piezo burst lengths in control ticks
package car_pkg;

  typedef enum logic [2:0] {
    GEAR_N = 3'd0,
    GEAR_1 = 3'd1,
    GEAR_2 = 3'd2,
    GEAR_3 = 3'd3,
    GEAR_4 = 3'd4,
    GEAR_5 = 3'd5,
    GEAR_6 = 3'd6,
    GEAR_R = 3'd7
  } gear_e;

  // Element 0 is the rightmost nibble, so MAX_LEVEL[gear] reads naturally.
  localparam logic [7:0][3:0] MAX_LEVEL = {
    4'd3, 4'd13, 4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd0
  };

  localparam int INITIAL_HOLD_DEFAULT = 300;
  localparam int REPEAT_DEFAULT       = 150;

  localparam int BEEP_OK_TICKS  = 50;
  localparam int BEEP_ERR_TICKS = 200;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_N     = 8'h37;
  localparam logic [7:0] SEG_R     = 8'h50;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] gear_glyph(input gear_e g);
    logic [7:0] s;
    case (g)
      GEAR_N:  s = SEG_N;
      GEAR_R:  s = SEG_R;
      default: s = seg_digit({1'b0, g});
    endcase
    return s;
  endfunction

endpackage

// File: rtl/button_repeat.sv
// Button synchroniser + tick-sampled debounce + auto-repeat.
//   clk, rst : system clock, synchronous active-high reset
//   tick     : control tick enable
//   btn      : raw active-high button
//   step     : one-clock pulse per accepted press / repeat
module button_repeat #(
  parameter int INITIAL_HOLD = 300,
  parameter int REPEAT       = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic step
);

  localparam int HMAX = (INITIAL_HOLD > REPEAT) ? INITIAL_HOLD : REPEAT;
  localparam int HW   = $clog2(HMAX + 1);

  logic [1:0]    sync;
  logic          smp;
  logic [HW-1:0] hold_cnt;   // ticks remaining until the next repeat; 0 = idle
  logic          cur;

  assign cur = sync[1];

  // smp resets high so a button still held through reset is not seen as a
  // new press; with hold_cnt at 0 the held button then stays silent until
  // it is released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      smp      <= 1'b1;
      hold_cnt <= '0;
      step     <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      step <= 1'b0;
      if (tick) begin
        smp <= cur;
        if (cur && !smp) begin
          step     <= 1'b1;
          hold_cnt <= HW'(INITIAL_HOLD);
        end else if (cur && hold_cnt != '0) begin
          if (hold_cnt == HW'(1)) begin
            step     <= 1'b1;
            hold_cnt <= HW'(REPEAT);
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end else if (!cur) begin
          hold_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div.sv
// Control-tick generator.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clk_1khz : 50% square wave at TICK_HZ (observable, never used as a clock)
//   tick     : one-clock enable on each clk_1khz rising edge
module clk_div #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1_000
) (
  input  logic clk,
  input  logic rst,
  output logic clk_1khz,
  output logic tick
);

  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int CW   = $clog2(HALF + 1);

  logic [CW-1:0] cnt;
  logic          clk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      clk_1khz <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      clk_q <= clk_1khz;
      if (cnt == CW'(HALF - 1)) begin
        cnt      <= '0;
        clk_1khz <= ~clk_1khz;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign tick = clk_1khz & ~clk_q;

endmodule

// File: rtl/rpm_ctrl.sv
// Speed level register with per-gear clamp.
//   clk, rst    : system clock, synchronous active-high reset
//   tick        : control tick enable (used for the gear clamp)
//   acc_step    : accelerate pulse
//   dec_step    : decelerate pulse
//   gear        : current gear
//   speed_level : 0..max_level
//   max_level   : ceiling for the current gear
//   beep_ok     : one-clock pulse, speed changed
//   beep_err    : one-clock pulse, step refused at a limit
module rpm_ctrl
  import car_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       acc_step,
  input  logic       dec_step,
  input  gear_e      gear,
  output logic [3:0] speed_level,
  output logic [3:0] max_level,
  output logic       beep_ok,
  output logic       beep_err
);

  assign max_level = MAX_LEVEL[gear];

  // Steps arrive the clock after a tick, so they never collide with the
  // clamp, which only acts on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_level <= 4'd0;
      beep_ok     <= 1'b0;
      beep_err    <= 1'b0;
    end else begin
      beep_ok  <= 1'b0;
      beep_err <= 1'b0;
      if (tick && speed_level > max_level) begin
        speed_level <= max_level;
      end else if (acc_step && !dec_step) begin
        if (speed_level < max_level) begin
          speed_level <= speed_level + 4'd1;
          beep_ok     <= 1'b1;
        end else begin
          beep_err <= 1'b1;
        end
      end else if (dec_step && !acc_step) begin
        if (speed_level != 4'd0) begin
          speed_level <= speed_level - 4'd1;
          beep_ok     <= 1'b1;
        end else begin
          beep_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/car_rpm_top.sv
// Car-dashboard top: buttons -> speed level -> gauge, RPM FND, LEDs, piezo.
//   clk_50mhz     : system clock
//   rst_btn       : synchronous active-high reset
//   btn_accel     : accelerate button
//   btn_decel     : decelerate button
//   gear_sw       : 0=N, 1..6, 7=R
//   servo_pwm     : 50 Hz gauge PWM, 1.0..2.0 ms high
//   speed_fnd_sel : digit select, active-low one-hot, bit 0 = rightmost
//   speed_fnd_seg : segments {dp,g..a}
//   gear_seg      : gear glyph {dp,g..a}
//   leds          : speed bar graph
//   piezo         : beeper
module car_rpm_top
  import car_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1_000,
  parameter int INITIAL_HOLD = INITIAL_HOLD_DEFAULT,
  parameter int REPEAT       = REPEAT_DEFAULT
) (
  input  logic       clk_50mhz,
  input  logic       rst_btn,
  input  logic       btn_accel,
  input  logic       btn_decel,
  input  logic [2:0] gear_sw,
  output logic       servo_pwm,
  output logic [7:0] speed_fnd_sel,
  output logic [7:0] speed_fnd_seg,
  output logic [7:0] gear_seg,
  output logic [7:0] leds,
  output logic       piezo
);

  localparam int PWM_PERIOD = CLK_HZ / 50;
  localparam int PWM_MIN    = CLK_HZ / 1000;
  localparam int PWM_STEP   = CLK_HZ / 15000;
  localparam int PW         = $clog2(PWM_PERIOD);
  localparam int BW         = $clog2(BEEP_ERR_TICKS + 1);

  logic       tick, clk_1khz;
  logic       acc_step, dec_step, beep_ok, beep_err;
  logic [3:0] speed_level, max_level;
  gear_e      gear;

  // Gear comes from static slide switches; decoded directly.
  assign gear     = gear_e'(gear_sw);
  assign gear_seg = gear_glyph(gear);

  clk_div #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_clk_div (
    .clk(clk_50mhz), .rst(rst_btn), .clk_1khz(clk_1khz), .tick(tick)
  );

  button_repeat #(.INITIAL_HOLD(INITIAL_HOLD), .REPEAT(REPEAT)) u_btn_accel (
    .clk(clk_50mhz), .rst(rst_btn), .tick(tick), .btn(btn_accel), .step(acc_step)
  );

  button_repeat #(.INITIAL_HOLD(INITIAL_HOLD), .REPEAT(REPEAT)) u_btn_decel (
    .clk(clk_50mhz), .rst(rst_btn), .tick(tick), .btn(btn_decel), .step(dec_step)
  );

  rpm_ctrl u_rpm_ctrl (
    .clk(clk_50mhz), .rst(rst_btn), .tick(tick),
    .acc_step(acc_step), .dec_step(dec_step), .gear(gear),
    .speed_level(speed_level), .max_level(max_level),
    .beep_ok(beep_ok), .beep_err(beep_err)
  );

  // ---------------- servo gauge ----------------
  logic [PW-1:0] pwm_cnt, pwm_high;

  assign pwm_high = PW'(PWM_MIN) + PW'(speed_level) * PW'(PWM_STEP);

  always_ff @(posedge clk_50mhz) begin
    if (rst_btn) begin
      pwm_cnt   <= '0;
      servo_pwm <= 1'b0;
    end else begin
      pwm_cnt   <= (pwm_cnt == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 1'b1;
      servo_pwm <= (pwm_cnt < pwm_high);
    end
  end

  // ---------------- RPM FND scan ----------------
  // rpm = speed*500: thousands = speed/2, hundreds = 5 on odd speeds,
  // tens and ones are always 0.
  logic [2:0] scan_dig;
  logic [3:0] rpm_th, rpm_hu;
  logic [7:0] seg_nxt;

  assign rpm_th = speed_level >> 1;
  assign rpm_hu = speed_level[0] ? 4'd5 : 4'd0;

  always_comb begin
    seg_nxt = SEG_BLANK;
    case (scan_dig)
      3'd0:    seg_nxt = seg_digit(4'd0);
      3'd1:    if (speed_level != 4'd0) seg_nxt = seg_digit(4'd0);
      3'd2:    if (speed_level != 4'd0) seg_nxt = seg_digit(rpm_hu);
      3'd3:    if (speed_level > 4'd1)  seg_nxt = seg_digit(rpm_th);
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst_btn) begin
      scan_dig      <= '0;
      speed_fnd_sel <= 8'hFF;
      speed_fnd_seg <= SEG_BLANK;
    end else begin
      if (tick) scan_dig <= scan_dig + 3'd1;
      speed_fnd_sel <= ~(8'd1 << scan_dig);
      speed_fnd_seg <= seg_nxt;
    end
  end

  // ---------------- LED bar ----------------
  for (genvar i = 0; i < 8; i++) begin : g_led
    assign leds[i] = (speed_level > 4'(2 * i));
  end

  // ---------------- piezo ----------------
  // A refusal burst overrides an acceptance burst if both are pending.
  logic [BW-1:0] beep_cnt;

  always_ff @(posedge clk_50mhz) begin
    if (rst_btn) begin
      beep_cnt <= '0;
      piezo    <= 1'b0;
    end else if (beep_err) begin
      beep_cnt <= BW'(BEEP_ERR_TICKS);
    end else if (beep_ok) begin
      beep_cnt <= BW'(BEEP_OK_TICKS);
    end else if (tick) begin
      if (beep_cnt != '0) begin
        piezo    <= ~piezo;
        beep_cnt <= beep_cnt - 1'b1;
      end else begin
        piezo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_car_rpm_top.sv
module tb_car_rpm_top;

  localparam int CLK_HZ    = 15_000;
  localparam int TICK_HZ   = 1_000;
  localparam int TICK_CLKS = 2 * (CLK_HZ / (2 * TICK_HZ));
  localparam int IH        = 300;
  localparam int RP        = 150;

  logic       clk_50mhz = 1'b0;
  logic       rst_btn   = 1'b1;
  logic       btn_accel = 1'b0;
  logic       btn_decel = 1'b0;
  logic [2:0] gear_sw   = 3'd6;
  logic       servo_pwm, piezo;
  logic [7:0] speed_fnd_sel, speed_fnd_seg, gear_seg, leds;

  int n_vec = 0;
  int n_mis = 0;
  int m_speed = 0;
  int m_gear  = 6;

  car_rpm_top #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk_50mhz(clk_50mhz), .rst_btn(rst_btn), .btn_accel(btn_accel),
    .btn_decel(btn_decel), .gear_sw(gear_sw), .servo_pwm(servo_pwm),
    .speed_fnd_sel(speed_fnd_sel), .speed_fnd_seg(speed_fnd_seg),
    .gear_seg(gear_seg), .leds(leds), .piezo(piezo)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk_50mhz);
      cyc++;
      if (cyc > 95000) begin
        $display("FAIL watchdog: run exceeded %0d clocks", cyc);
        $fatal(1, "watchdog");
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int max_of(input int g);
    case (g)
      0: return 0;  1: return 3;  2: return 5;  3: return 7;
      4: return 9;  5: return 11; 6: return 13; default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; default: return 8'h6F;
    endcase
  endfunction

  function automatic logic [7:0] gear_exp(input int g);
    if (g == 0) return 8'h37;
    if (g == 7) return 8'h50;
    return glyph(g);
  endfunction

  function automatic logic [7:0] fnd_exp(input int spd, input int pos);
    int rpm, p10;
    rpm = spd * 500;
    p10 = 1;
    for (int j = 0; j < pos; j++) p10 = p10 * 10;
    if (pos > 3) return 8'h00;
    if (pos > 0 && rpm < p10) return 8'h00;
    return glyph((rpm / p10) % 10);
  endfunction

  function automatic logic [7:0] leds_exp(input int spd);
    logic [7:0] l;
    for (int i = 0; i < 8; i++) l[i] = (spd > 2 * i);
    return l;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge dut.u_clk_div.clk_1khz);
    @(negedge clk_50mhz);
  endtask

  task automatic press(input bit a, input bit d, input int h);
    int n;
    @(posedge dut.u_clk_div.clk_1khz);
    @(negedge clk_50mhz);
    btn_accel = a;
    btn_decel = d;
    repeat (h) @(posedge dut.u_clk_div.clk_1khz);
    @(negedge clk_50mhz);
    btn_accel = 1'b0;
    btn_decel = 1'b0;
    ticks(2);
    n = 1 + ((h > IH) ? (h - IH + RP - 1) / RP : 0);
    if (a && !d) m_speed = (m_speed + n > max_of(m_gear)) ? max_of(m_gear) : m_speed + n;
    else if (d && !a) m_speed = (m_speed - n < 0) ? 0 : m_speed - n;
  endtask

  task automatic set_gear(input int g);
    @(negedge clk_50mhz);
    gear_sw = 3'(g);
    m_gear  = g;
    if (m_speed > max_of(g)) m_speed = max_of(g);
    ticks(2);
  endtask

  task automatic servo_high(output int hi);
    int guard;
    hi = 0;
    guard = 0;
    @(negedge clk_50mhz);
    while (servo_pwm !== 1'b0 && guard < 1000) begin @(negedge clk_50mhz); guard++; end
    while (servo_pwm !== 1'b1 && guard < 1000) begin @(negedge clk_50mhz); guard++; end
    while (servo_pwm === 1'b1 && guard < 1000) begin @(negedge clk_50mhz); hi++; guard++; end
  endtask

  task automatic check_fnd(input int spd);
    int p0, pos;
    logic [7:0] es;
    @(posedge dut.u_clk_div.clk_1khz);
    repeat (4) @(negedge clk_50mhz);
    p0 = -1;
    for (int i = 0; i < 8; i++) begin
      es = ~(8'd1 << i);
      if (speed_fnd_sel === es) p0 = i;
    end
    chk("fnd_sel_onehot", 32'(p0 >= 0), 32'd1);
    if (p0 < 0) p0 = 0;
    for (int k = 0; k < 8; k++) begin
      pos = (p0 + k) % 8;
      es  = ~(8'd1 << pos);
      chk("fnd_sel", 32'(speed_fnd_sel), 32'(es));
      chk("fnd_seg", 32'(speed_fnd_seg), 32'(fnd_exp(spd, pos)));
      @(posedge dut.u_clk_div.clk_1khz);
      repeat (4) @(negedge clk_50mhz);
    end
  endtask

  task automatic check_speed(input string tag);
    chk(tag, 32'(dut.u_rpm_ctrl.speed_level), 32'(m_speed));
    chk("leds", 32'(leds), 32'(leds_exp(m_speed)));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int hi, edges, g, mode, h;
    logic prev_pz;

    repeat (20) @(negedge clk_50mhz);
    chk("rst_speed", 32'(dut.u_rpm_ctrl.speed_level), 32'd0);
    chk("rst_max", 32'(dut.u_rpm_ctrl.max_level), 32'(max_of(6)));
    chk("rst_servo", 32'(servo_pwm), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_piezo", 32'(piezo), 32'd0);
    chk("rst_fnd_sel", 32'(speed_fnd_sel), 32'hFF);
    chk("rst_fnd_seg", 32'(speed_fnd_seg), 32'h00);
    chk("rst_gear_seg", 32'(gear_seg), 32'(gear_exp(6)));
    rst_btn = 1'b0;

    servo_high(hi);
    chk("servo_min", 32'(hi), 32'(CLK_HZ / 1000));

    press(1'b1, 1'b0, 50);  check_speed("accel_50");
    press(1'b1, 1'b0, 700); check_speed("accel_700");
    press(1'b0, 1'b1, 500); check_speed("decel_500");
    press(1'b1, 1'b0, 320); check_speed("accel_320");
    check_fnd(m_speed);
    servo_high(hi);
    chk("servo_lvl", 32'(hi), 32'(CLK_HZ / 1000 + m_speed * CLK_HZ / 15000));

    set_gear(1);
    check_speed("gear1_clamp");
    chk("gear1_max", 32'(dut.u_rpm_ctrl.max_level), 32'(max_of(1)));
    chk("gear1_seg", 32'(gear_seg), 32'(gear_exp(1)));

    // Refused accel at the ceiling: long burst, counted as piezo edges.
    ticks(60);
    edges = 0;
    prev_pz = piezo;
    fork
      begin
        repeat (230 * TICK_CLKS) begin
          @(negedge clk_50mhz);
          if (piezo !== prev_pz) edges++;
          prev_pz = piezo;
        end
      end
      begin
        @(posedge dut.u_clk_div.clk_1khz);
        @(negedge clk_50mhz);
        btn_accel = 1'b1;
        repeat (10) @(posedge dut.u_clk_div.clk_1khz);
        @(negedge clk_50mhz);
        btn_accel = 1'b0;
      end
    join
    chk("refuse_piezo_edges", 32'(edges), 32'(2 * 100));
    chk("refuse_piezo_idle", 32'(piezo), 32'd0);
    check_speed("refuse_speed");

    press(1'b1, 1'b1, 10); check_speed("both_cancel");

    set_gear(7);
    chk("gearR_seg", 32'(gear_seg), 32'(gear_exp(7)));
    chk("gearR_max", 32'(dut.u_rpm_ctrl.max_level), 32'(max_of(7)));
    set_gear(0);
    check_speed("gearN_clamp");
    chk("gearN_seg", 32'(gear_seg), 32'(gear_exp(0)));

    // Pump to the gear-6 ceiling with short presses.
    set_gear(6);
    for (int i = 0; i < 16; i++) press(1'b1, 1'b0, 2);
    check_speed("gear6_ceiling");
    check_fnd(m_speed);
    servo_high(hi);
    chk("servo_top", 32'(hi), 32'(CLK_HZ / 1000 + m_speed * CLK_HZ / 15000));

    for (int it = 0; it < 6; it++) begin
      g    = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      h    = $urandom_range(1, 350);
      set_gear(g);
      check_speed("rnd_gear");
      chk("rnd_gear_seg", 32'(gear_seg), 32'(gear_exp(g)));
      press(mode != 1, mode != 0, h);
      check_speed("rnd_press");
    end

    // Reset in the middle of a hold: no further step until a fresh press.
    @(posedge dut.u_clk_div.clk_1khz);
    @(negedge clk_50mhz);
    btn_accel = 1'b1;
    ticks(5);
    rst_btn = 1'b1;
    repeat (5) @(negedge clk_50mhz);
    rst_btn = 1'b0;
    m_speed = 0;
    ticks(20);
    check_speed("rst_midhold");
    btn_accel = 1'b0;
    ticks(2);
    press(1'b1, 1'b0, 3);
    check_speed("repress_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
